// File: rtl/dnn_train_sequencer.sv
// Training-loop controller: buffers samples and replays them to neural_network while stepping
// control through FORWARD/ERROR/BACKWARD/UPDATE. Define DNN_SEQ_INFER_EN for the forward-only mode.
module dnn_train_sequencer #(
  parameter int NUM_SAMPLES = 3,
  parameter int EPOCH_W     = 20,
  parameter int FWD_CYCLES  = 2,
  parameter int ERR_CYCLES  = 1,
  parameter int BWD_CYCLES  = 2,
  parameter int UPD_CYCLES  = 1
) (
  input  logic               clk,
  input  logic               set,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [31:0]        load_x1,
  input  logic [31:0]        load_x2,
  input  logic [31:0]        load_x3,
  input  logic [31:0]        load_target,
  input  logic               start,
  input  logic               abort,
`ifdef DNN_SEQ_INFER_EN
  input  logic               infer,
`endif
  input  logic [EPOCH_W-1:0] max_epochs,
  output logic [31:0]        x1,
  output logic [31:0]        x2,
  output logic [31:0]        x3,
  output logic [31:0]        target_out,
  output logic [2:0]         control,
  output logic               busy,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [2:0]         sample_idx,
  output logic [3:0]         sample_count
);

  localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  // State codes double as the control code driven to the network.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FWD  = 3'd1,
    S_ERR  = 3'd2,
    S_BWD  = 3'd3,
    S_UPD  = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] x3;
    logic [31:0] tgt;
  } sample_t;

  state_t               state_q, state_d;
  logic [7:0]           ph_q, ph_d;
  logic [2:0]           idx_q, idx_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic [EPOCH_W-1:0]   limit_q, limit_d;
  logic                 abort_q, abort_d;
  logic                 infer_q, infer_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  sample_t              cur_q, cur_d;
  sample_t              mem_q [NUM_SAMPLES];

  logic                 infer_in;
  logic                 wr_en;
  logic                 sample_end;
  logic                 last_sample;
  logic                 dwell_last;
  logic [7:0]           dwell_len;
  logic [EPOCH_W-1:0]   epoch_inc;
  sample_t              load_s;

`ifdef DNN_SEQ_INFER_EN
  assign infer_in = infer;
`else
  assign infer_in = 1'b0;
`endif

  assign load_s = '{x1: load_x1, x2: load_x2, x3: load_x3, tgt: load_target};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    ph_d        = ph_q;
    idx_d       = idx_q;
    epoch_d     = epoch_q;
    limit_d     = limit_q;
    infer_d     = infer_q;
    cur_d       = cur_q;
    done_d      = 1'b0;
    sample_end  = 1'b0;
    dwell_len   = 8'd1;

    wr_en       = load_valid && ready_q;
    cnt_d       = wr_en ? cnt_q + 4'd1 : cnt_q;
    last_sample = ({1'b0, idx_q} == cnt_q - 4'd1);
    epoch_inc   = (&epoch_q) ? epoch_q : epoch_q + 1'b1;

    case (state_q)
      S_FWD:   dwell_len = 8'(FWD_CYCLES);
      S_ERR:   dwell_len = 8'(ERR_CYCLES);
      S_BWD:   dwell_len = 8'(BWD_CYCLES);
      S_UPD:   dwell_len = 8'(UPD_CYCLES);
      default: dwell_len = 8'd1;
    endcase
    dwell_last = (ph_q == dwell_len - 8'd1);

    case (state_q)
      S_IDLE: begin
        // A load accepted on the same edge as start is part of the run, hence cnt_d.
        if (start && cnt_d != 4'd0) begin
          state_d = S_FWD;
          ph_d    = 8'd0;
          idx_d   = 3'd0;
          epoch_d = '0;
          limit_d = max_epochs;
          infer_d = infer_in;
          cur_d   = (wr_en && cnt_q == 4'd0) ? load_s : mem_q[0];
        end
      end
      S_FWD: begin
        ph_d = ph_q + 8'd1;
        if (dwell_last) begin
          state_d = S_ERR;
          ph_d    = 8'd0;
        end
      end
      S_ERR: begin
        ph_d = ph_q + 8'd1;
        if (dwell_last) begin
          if (infer_q) begin
            sample_end = 1'b1;
          end else begin
            state_d = S_BWD;
            ph_d    = 8'd0;
          end
        end
      end
      S_BWD: begin
        ph_d = ph_q + 8'd1;
        if (dwell_last) begin
          state_d = S_UPD;
          ph_d    = 8'd0;
        end
      end
      S_UPD: begin
        ph_d = ph_q + 8'd1;
        if (dwell_last) sample_end = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (sample_end) begin
      ph_d = 8'd0;
      if (last_sample) begin
        idx_d   = 3'd0;
        epoch_d = epoch_inc;
      end else begin
        idx_d   = idx_q + 3'd1;
      end
      if (abort_q || abort ||
          (limit_q != '0 && last_sample && epoch_inc == limit_q)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = S_FWD;
        cur_d   = mem_q[idx_d[IDX_W-1:0]];
      end
    end

    // Abort is only remembered while a run is in flight and dies with the return to IDLE.
    abort_d = (state_d != S_IDLE) && (abort_q || (state_q != S_IDLE && abort));
    ready_d = (state_d == S_IDLE) && (cnt_d < 4'(NUM_SAMPLES));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (set) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      epoch_q <= '0;
      limit_q <= '0;
      abort_q <= 1'b0;
      infer_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      epoch_q <= epoch_d;
      limit_q <= limit_d;
      abort_q <= abort_d;
      infer_q <= infer_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      cur_q   <= cur_d;
    end
  end

  // NOTE: the sample buffer is deliberately not reset; cnt_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q[IDX_W-1:0]] <= load_s;
  end

  assign load_ready   = ready_q;
  assign control      = state_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign epoch_count  = epoch_q;
  assign sample_idx   = idx_q;
  assign sample_count = cnt_q;
  assign x1           = cur_q.x1;
  assign x2           = cur_q.x2;
  assign x3           = cur_q.x3;
  assign target_out   = cur_q.tgt;

endmodule

// File: tb/tb_dnn_train_sequencer.sv
// Self-checking bench for dnn_train_sequencer: a trace model fills a scoreboard queue per run,
// and a negedge monitor pops and compares every cycle the DUT is busy or pulsing done.
module tb_dnn_train_sequencer;

  localparam int NS  = 3;
  localparam int EW  = 20;
  localparam int FWD = 2;
  localparam int ERR = 1;
  localparam int BWD = 2;
  localparam int UPD = 1;

  typedef struct {
    logic [2:0]    ctl;
    logic [2:0]    idx;
    logic [31:0]   x1, x2, x3, tgt;
    logic          busy;
    logic          done;
    logic [EW-1:0] epoch;
  } exp_t;

  logic          clk = 1'b0;
  logic          set = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [31:0]   load_x1 = '0, load_x2 = '0, load_x3 = '0, load_target = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          infer = 1'b0;
  logic [EW-1:0] max_epochs = '0;
  logic [31:0]   x1, x2, x3, target_out;
  logic [2:0]    control;
  logic          busy, done;
  logic [EW-1:0] epoch_count;
  logic [2:0]    sample_idx;
  logic [3:0]    sample_count;

  int n_checks = 0;
  int n_errors = 0;

  exp_t        exp_q[$];
  logic [31:0] m_x1[NS], m_x2[NS], m_x3[NS], m_tg[NS];
  int          m_cnt = 0;

  dnn_train_sequencer #(
    .NUM_SAMPLES(NS), .EPOCH_W(EW), .FWD_CYCLES(FWD),
    .ERR_CYCLES(ERR), .BWD_CYCLES(BWD), .UPD_CYCLES(UPD)
  ) dut (
    .clk(clk), .set(set),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_x1(load_x1), .load_x2(load_x2), .load_x3(load_x3), .load_target(load_target),
    .start(start), .abort(abort),
`ifdef DNN_SEQ_INFER_EN
    .infer(infer),
`endif
    .max_epochs(max_epochs),
    .x1(x1), .x2(x2), .x3(x3), .target_out(target_out),
    .control(control), .busy(busy), .done(done),
    .epoch_count(epoch_count), .sample_idx(sample_idx), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any busy or done cycle must match the next predicted trace entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!set && (busy || done)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {61'd0, control}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_control", {61'd0, control}, {61'd0, e.ctl});
          check("sb_idx",     {61'd0, sample_idx}, {61'd0, e.idx});
          check("sb_x1",      {32'd0, x1}, {32'd0, e.x1});
          check("sb_x2",      {32'd0, x2}, {32'd0, e.x2});
          check("sb_x3",      {32'd0, x3}, {32'd0, e.x3});
          check("sb_target",  {32'd0, target_out}, {32'd0, e.tgt});
          check("sb_busy",    {63'd0, busy}, {63'd0, e.busy});
          check("sb_done",    {63'd0, done}, {63'd0, e.done});
          check("sb_epoch",   {44'd0, epoch_count}, {44'd0, e.epoch});
        end
      end
    end
  end

  task automatic do_reset();
    set = 1'b1;
    tick();
    tick();
    check("rst_control", {61'd0, control}, 64'd0);
    check("rst_busy",    {63'd0, busy}, 64'd0);
    check("rst_done",    {63'd0, done}, 64'd0);
    check("rst_epoch",   {44'd0, epoch_count}, 64'd0);
    check("rst_idx",     {61'd0, sample_idx}, 64'd0);
    check("rst_count",   {60'd0, sample_count}, 64'd0);
    check("rst_x1",      {32'd0, x1}, 64'd0);
    check("rst_target",  {32'd0, target_out}, 64'd0);
    check("rst_ready",   {63'd0, load_ready}, 64'd0);
    set = 1'b0;
    tick();
    check("post_rst_ready", {63'd0, load_ready}, 64'd1);
    exp_q.delete();
    m_cnt = 0;
  endtask

  task automatic load_sample(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] t);
    load_valid = 1'b1;
    load_x1 = a; load_x2 = b; load_x3 = c; load_target = t;
    if (m_cnt < NS) begin
      m_x1[m_cnt] = a; m_x2[m_cnt] = b; m_x3[m_cnt] = c; m_tg[m_cnt] = t;
      m_cnt++;
    end
    tick();
    load_valid = 1'b0;
  endtask

  // Builds the expected trace from the phase rules, then starts the DUT and steps it.
  // abort_at / set_at / poke_at are cycle numbers after start (cycle 1 = first FORWARD cycle), 0 = none.
  task automatic run_training(input int max_ep, input int abort_at, input int set_at,
                              input int poke_at, input bit co_load, input bit inf);
    int   ph_len[4];
    int   n_ph, period, blocks, epochs, c, s;
    bit   stop;
    exp_t e;
    ph_len[0] = FWD; ph_len[1] = ERR; ph_len[2] = BWD; ph_len[3] = UPD;
    n_ph = inf ? 2 : 4;
    period = 0;
    for (int p = 0; p < n_ph; p++) period += ph_len[p];

    if (co_load) begin
      load_valid = 1'b1;
      load_x1 = $urandom; load_x2 = $urandom; load_x3 = $urandom; load_target = $urandom;
      if (m_cnt < NS) begin
        m_x1[m_cnt] = load_x1; m_x2[m_cnt] = load_x2;
        m_x3[m_cnt] = load_x3; m_tg[m_cnt] = load_target;
        m_cnt++;
      end
    end

    blocks = 0; epochs = 0; stop = 1'b0;
    while (!stop) begin
      s = blocks % m_cnt;
      for (int p = 0; p < n_ph; p++)
        for (int k = 0; k < ph_len[p]; k++) begin
          e.ctl = 3'(p + 1); e.idx = 3'(s);
          e.x1 = m_x1[s]; e.x2 = m_x2[s]; e.x3 = m_x3[s]; e.tgt = m_tg[s];
          e.busy = 1'b1; e.done = 1'b0; e.epoch = EW'(epochs);
          exp_q.push_back(e);
        end
      blocks++;
      if (blocks % m_cnt == 0) epochs++;
      if ((abort_at > 0 && abort_at <= blocks * period) ||
          (max_ep != 0 && blocks % m_cnt == 0 && epochs == max_ep)) stop = 1'b1;
    end
    e.ctl = 3'd0; e.idx = 3'(blocks % m_cnt);
    e.x1 = m_x1[(blocks - 1) % m_cnt]; e.x2 = m_x2[(blocks - 1) % m_cnt];
    e.x3 = m_x3[(blocks - 1) % m_cnt]; e.tgt = m_tg[(blocks - 1) % m_cnt];
    e.busy = 1'b0; e.done = 1'b1; e.epoch = EW'(epochs);
    exp_q.push_back(e);

    max_epochs = EW'(max_ep);
    infer = inf;
    start = 1'b1;
    tick();
    start = 1'b0; load_valid = 1'b0;
    max_epochs = EW'($urandom);
    infer = ~inf;
    c = 1;
    check("first_control", {61'd0, control}, 64'd1);
    while (done !== 1'b1 && c < 2000) begin
      if (c == set_at) begin
        set = 1'b1;
        tick();
        set = 1'b0;
        check("set_control", {61'd0, control}, 64'd0);
        check("set_count",   {60'd0, sample_count}, 64'd0);
        check("set_busy",    {63'd0, busy}, 64'd0);
        check("set_done",    {63'd0, done}, 64'd0);
        exp_q.delete();
        m_cnt = 0;
        return;
      end
      abort = (c == abort_at);
      if (c == poke_at) begin
        start = 1'b1; load_valid = 1'b1;
        load_x1 = $urandom; load_x2 = $urandom; load_x3 = $urandom; load_target = $urandom;
      end
      tick();
      c++;
      abort = 1'b0; start = 1'b0; load_valid = 1'b0;
    end
    check("done_cycle",  64'(c), 64'(blocks * period + 1));
    check("done_epochs", {44'd0, epoch_count}, 64'(epochs));
    tick();
    check("trace_drained", 64'(exp_q.size()), 64'd0);
    check("count_kept",    {60'd0, sample_count}, 64'(m_cnt));
  endtask

  initial begin
    int k, me, ab;
    do_reset();

    load_sample(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F400000);
    load_sample(32'h40400000, 32'h40400000, 32'h40400000, 32'h3F000000);
    load_sample(32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h3EC00000);
    check("full_count", {60'd0, sample_count}, 64'd3);
    check("full_ready", {63'd0, load_ready}, 64'd0);
    load_sample(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    check("fourth_ignored", {60'd0, sample_count}, 64'd3);

    // Two epochs, with a stray start+load while busy that must be ignored.
    run_training(2, 0, 0, 4, 1'b0, 1'b0);
    // Run-until-abort, abort raised during sample 1 BACKWARD.
    run_training(0, 10, 0, 0, 1'b0, 1'b0);
    // Reset in the middle of ERROR.
    run_training(5, 0, 3, 0, 1'b0, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("empty_start_busy",    {63'd0, busy}, 64'd0);
    check("empty_start_control", {61'd0, control}, 64'd0);

    // Load and start on the same edge into an empty buffer.
    run_training(2, 0, 0, 0, 1'b1, 1'b0);

    for (int it = 0; it < 6; it++) begin
      do_reset();
      k = $urandom_range(1, NS);
      for (int j = 0; j < k; j++) load_sample($urandom, $urandom, $urandom, $urandom);
      check("rand_count", {60'd0, sample_count}, 64'(k));
      me = $urandom_range(1, 3);
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 50) : 0;
      run_training(me, ab, 0, $urandom_range(0, 8), 1'b0, 1'b0);
    end

`ifdef DNN_SEQ_INFER_EN
    do_reset();
    load_sample(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F400000);
    load_sample(32'h40400000, 32'h40400000, 32'h40400000, 32'h3F000000);
    load_sample(32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h3EC00000);
    run_training(1, 0, 0, 0, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dnn_train_sequencer.md
# dnn_train_sequencer

Training-loop controller for the floating-point `neural_network` datapath. Buffers a small set of training samples, replays them to the network's `x1`/`x2`/`x3`/`target_out` inputs, and steps the network's 3-bit `control` through FORWARD → ERROR → BACKWARD → UPDATE for each sample, over a programmable number of epochs. Sits between the sample loader (host/testbench/DMA) and `neural_network`, and replaces hand-timed stimulus.

## Interface
- `NUM_SAMPLES`, 3: sample buffer depth (1..8).
- `EPOCH_W`, 20: width of the epoch counter and limit.
- `FWD_CYCLES`, 2: cycles spent in FORWARD (≥1).
- `ERR_CYCLES`, 1: cycles in ERROR (≥1).
- `BWD_CYCLES`, 2: cycles in BACKWARD (≥1).
- `UPD_CYCLES`, 1: cycles in UPDATE (≥1).

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `set` in 1: synchronous, active-high reset.
- `load_valid` in 1: loader presents a sample.
- `load_ready` out 1: buffer accepts a sample this cycle.
- `load_x1`, `load_x2`, `load_x3`, `load_target` in 32 each: IEEE-754 single sample fields.
- `start` in 1: begin training, sampled only in IDLE.
- `abort` in 1: stop training at the next sample boundary.
- `max_epochs` in EPOCH_W: epoch limit, latched at start; 0 means run until abort.
- `x1`, `x2`, `x3`, `target_out` out 32 each: to the network.
- `control` out 3: phase code to the network.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on completion.
- `epoch_count` out EPOCH_W: completed epochs.
- `sample_idx` out 3: index of the sample currently presented.
- `sample_count` out 4: number of buffered samples.

## Operation
- `control` encoding: 0 IDLE, 1 FORWARD, 2 ERROR, 3 BACKWARD, 4 UPDATE. Codes 5–7 are never driven.
- States: IDLE, FWD, ERR, BWD, UPD. A phase counter dwells the configured number of cycles in each state, then advances.
- Loading:
  - `load_ready` = IDLE && `sample_count` < NUM_SAMPLES.
  - On `load_valid && load_ready`, the sample is written at index `sample_count`, and `sample_count` increments.
  - Loading while full or busy is ignored, with no overwrite.
- `start` in IDLE with `sample_count` > 0:
  - latch `max_epochs`;
  - clear `epoch_count` and `sample_idx`;
  - enter FWD with sample 0.
- `start` with `sample_count` = 0 is ignored. `start` while busy is ignored.
- UPD exit:
  - if `sample_idx` = `sample_count`−1: `sample_idx` wraps to 0 and `epoch_count` increments;
  - otherwise `sample_idx` increments.
- Termination is decided at UPD exit:
  - if `abort` is pending, or the latched limit ≠ 0 and the incremented `epoch_count` equals it → IDLE with a `done` pulse;
  - else → FWD with the next sample.
- `abort` is latched (sticky) while busy and cleared on entering IDLE. `abort` in IDLE has no effect.
- `epoch_count` saturates at all-ones when the limit = 0.
- The buffer keeps its contents after `done`, so a new `start` reruns the same set. Only `set` empties it.

## Timing
- Reset values, taking effect on the first edge with `set` = 1:
  - state IDLE, `control` = 0, `busy` = 0, `done` = 0;
  - `epoch_count` = 0, `sample_idx` = 0, `sample_count` = 0;
  - `x1`/`x2`/`x3`/`target_out` = 0;
  - `load_ready` = 0 during reset, 1 on the first cycle after.
- `set` mid-training: returns to IDLE on that edge, with no `done` pulse.
- All outputs are registered. `start` seen at edge N → `control` = 1 and sample 0 on the outputs after edge N.
- Sample data changes only on the edge entering FWD and stays stable through all four phases.
- Per-sample period = FWD+ERR+BWD+UPD cycles; the default is 6. There are no idle gaps between samples or epochs.
- `done` is high the cycle after the final UPD cycle, concurrent with `control` = 0 and `busy` = 0.
- Simultaneous `start` and `load_valid` in IDLE: the load is accepted first, and training includes that sample.

## Configuration
- `DNN_SEQ_INFER_EN`:
  - Defined: adds input `infer` (1 bit), latched at `start`. When latched high, each sample runs FWD → ERR only, skipping BWD/UPD, and epoch/termination logic runs at ERR exit. The per-sample period is FWD+ERR.
  - Undefined: no `infer` port; every sample runs all four phases.

## Test plan
- Reset, then load three samples:
  - 0x3F800000×3 with target 0x3F400000;
  - 0x40400000×3 with target 0x3F000000;
  - 0x40C00000×3 with target 0x3EC00000.
  - Required: `sample_count` = 3, `load_ready` = 0, a fourth load is ignored.
- `max_epochs` = 2, `start` → `control` sequence 1,1,2,3,3,4 per sample. Samples are presented in order 0,1,2,0,1,2. `done` pulses at cycle 37 after start, and `epoch_count` = 2.
- `max_epochs` = 0, assert `abort` during sample 1 BWD → sample 1 finishes UPD, then IDLE with `done`. `epoch_count` = 0.
- `set` asserted mid-ERR → next cycle `control` = 0, `sample_count` = 0, `busy` = 0, no `done`.
- `start` with an empty buffer, or `start` while busy → no state change.
- With `DNN_SEQ_INFER_EN` and `infer` = 1, `max_epochs` = 1 → `control` 1,1,2 per sample, and `done` 10 cycles after start.
